// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared sizes and types for the AArch64 integer register file
// Revision    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam int unsigned XZR_IDX  = NUM_REGS - 1;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_idx_t XZR_ADDR = reg_idx_t'(XZR_IDX);

endpackage

`default_nettype wire

// File: rtl/regfile_if.sv
// ============================================================================
// regfile_if : write-back and operand-read signals of the register file
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface regfile_if;
  import regfile_pkg::*;

  logic      wr_en;
  reg_idx_t  wr_addr;
  reg_data_t wr_data;
  reg_idx_t  rd_addr1;
  reg_data_t rd_data1;
  reg_idx_t  rd_addr2;
  reg_data_t rd_data2;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
    output rd_data1, rd_data2
  );

endinterface

`default_nettype wire

// File: rtl/decoder_5_32.sv
// ============================================================================
// decoder_5_32 : write address + strobe to one-hot per-register write enable
// Revision     : 1.0
// ============================================================================
`default_nettype none

module decoder_5_32
  import regfile_pkg::*;
(
  input  wire logic                en,
  input  wire reg_idx_t            addr,
  output logic [NUM_REGS-1:0]      onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_32x64.sv
// ============================================================================
// regfile_32x64 : X0..X30 + XZR, two async read ports, one sync write port.
// Optional same-cycle write-through enabled by defining REGFILE_BYPASS_EN.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module regfile_32x64
  import regfile_pkg::*;
(
  input  wire logic  clk,
  input  wire logic  rst_n,
  regfile_if.slave   bus
);

  logic [NUM_REGS-1:0] w_we;
  reg_data_t           w_regs [NUM_REGS];
  reg_data_t           w_rd1;
  reg_data_t           w_rd2;
  logic                w_unused_xzr_we;

  decoder_5_32 u_dec (
    .en     (bus.wr_en),
    .addr   (bus.wr_addr),
    .onehot (w_we)
  );

  // The XZR strobe is decoded but deliberately has no storage behind it.
  assign w_unused_xzr_we = w_we[XZR_IDX];

  for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_regs
    reg_data_t r_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (w_we[i]) begin
        r_q <= bus.wr_data;
      end
    end

    assign w_regs[i] = r_q;
  end

  assign w_regs[XZR_IDX] = '0;

  assign w_rd1 = w_regs[bus.rd_addr1];
  assign w_rd2 = w_regs[bus.rd_addr2];

`ifdef REGFILE_BYPASS_EN
  logic w_hit1;
  logic w_hit2;

  // Gated by rst_n so that reset forces every read to zero even mid-write.
  assign w_hit1 = rst_n && bus.wr_en && (bus.wr_addr == bus.rd_addr1) && (bus.rd_addr1 != XZR_ADDR);
  assign w_hit2 = rst_n && bus.wr_en && (bus.wr_addr == bus.rd_addr2) && (bus.rd_addr2 != XZR_ADDR);

  assign bus.rd_data1 = w_hit1 ? bus.wr_data : w_rd1;
  assign bus.rd_data2 = w_hit2 ? bus.wr_data : w_rd2;
`else
  assign bus.rd_data1 = w_rd1;
  assign bus.rd_data2 = w_rd2;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_32x64.sv
// ============================================================================
// tb_regfile_32x64 : directed scoreboard bench for regfile_32x64
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_32x64;
  import regfile_pkg::*;

  typedef struct {
    string       name;
    logic [63:0] e1;
    logic [63:0] e2;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_if bus ();

  regfile_32x64 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam logic [63:0] COLLIDE_PRE = 64'h22;
`else
  localparam logic [63:0] COLLIDE_PRE = 64'h11;
`endif

  localparam logic [63:0] V5  = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] V30 = 64'h1234;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
    bus.wr_en    = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rd_addr1 = a1;
    bus.rd_addr2 = a2;
  endtask

  task automatic expect_rd(input string n, input logic [63:0] e1, input logic [63:0] e2);
    exp_t e;
    e.name = n;
    e.e1   = e1;
    e.e2   = e2;
    exp_q.push_back(e);
  endtask

  // Monitor: reads are combinational, so sample mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.rd_data1 !== e.e1 || bus.rd_data2 !== e.e2) begin
          errors++;
          $display("FAIL %s: got rd1=%h rd2=%h, expected rd1=%h rd2=%h",
                   e.name, bus.rd_data1, bus.rd_data2, e.e1, e.e2);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd30);
    step();
    expect_rd("reset_hold", 64'h0, 64'h0);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      step();
      drive(1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i));
      expect_rd($sformatf("zero_after_reset_%0d", i), 64'h0, 64'h0);
    end

    step(); drive(1'b1, 5'd5, V5, 5'd0, 5'd0);        expect_rd("wr_x5_rd_x0", 64'h0, 64'h0);
    step(); drive(1'b1, 5'd30, V30, 5'd5, 5'd0);      expect_rd("x5_written", V5, 64'h0);
    step(); drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd30);    expect_rd("rd_5_30", V5, V30);
    step(); drive(1'b0, 5'd0, 64'h0, 5'd30, 5'd5);    expect_rd("rd_30_5", V30, V5);

    step(); drive(1'b1, 5'd31, '1, 5'd31, 5'd31);     expect_rd("xzr_wr_no_bypass", 64'h0, 64'h0);
    step(); drive(1'b0, 5'd0, 64'h0, 5'd31, 5'd5);    expect_rd("xzr_after_wr", 64'h0, V5);
    step(); drive(1'b0, 5'd0, 64'h0, 5'd30, 5'd0);    expect_rd("others_after_xzr_wr", V30, 64'h0);

    step(); drive(1'b1, 5'd7, 64'h11, 5'd0, 5'd0);    expect_rd("wr_x7_11", 64'h0, 64'h0);
    step(); drive(1'b1, 5'd7, 64'h22, 5'd7, 5'd7);    expect_rd("collide_pre_edge", COLLIDE_PRE, COLLIDE_PRE);
    step(); drive(1'b0, 5'd0, 64'h0, 5'd7, 5'd7);     expect_rd("collide_post_edge", 64'h22, 64'h22);

    step(); drive(1'b1, 5'd3, 64'h77, 5'd0, 5'd0);    expect_rd("wr_x3_77", 64'h0, 64'h0);
    for (int k = 0; k < 4; k++) begin
      step(); drive(1'b0, 5'd3, 64'h55, 5'd3, 5'd3);
      expect_rd($sformatf("x3_hold_%0d", k), 64'h77, 64'h77);
    end
    step(); drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd3);     expect_rd("x5_x3_after_hold", V5, 64'h77);

    step(); drive(1'b1, 5'd9, 64'hAA, 5'd0, 5'd0);    expect_rd("wr_x9_aa", 64'h0, 64'h0);
    step(); drive(1'b0, 5'd0, 64'h0, 5'd9, 5'd9);     expect_rd("x9_written", 64'hAA, 64'hAA);
    step(); drive(1'b1, 5'd9, 64'hBB, 5'd9, 5'd5);
    rst_n = 1'b0;
    expect_rd("async_reset_mid_cycle", 64'h0, 64'h0);
    step(); expect_rd("reset_wins_over_write", 64'h0, 64'h0);
    step(); drive(1'b0, 5'd0, 64'h0, 5'd9, 5'd30);
    rst_n = 1'b1;
    expect_rd("after_reset_release", 64'h0, 64'h0);

    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
